// File: rtl/taxi_axis_if.sv
// rtl/taxi_axis_if.sv - AXI4-Stream bundle with source/sink modports
interface taxi_axis_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W/8,
    parameter int ID_W   = 8,
    parameter int DEST_W = 8,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_eth_frame_gen.sv
// rtl/taxi_eth_frame_gen.sv - Ethernet test-frame generator feeding a 64-bit MAC TX stream
module taxi_eth_frame_gen #(
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W/8,
    parameter int MAX_LEN = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    taxi_axis_if.src    m_axis_tx,
    input  logic        enable,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [15:0] cfg_eth_type,
    input  logic [15:0] cfg_len,
    input  logic [15:0] cfg_ifg,
    input  logic [31:0] cfg_count,
    output logic        busy,
    output logic        done,
    output logic [31:0] stat_frames
);

    if (DATA_W != 64) begin : g_bad_width
        $error("taxi_eth_frame_gen supports DATA_W=64 only");
    end

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_FRAME = 2'd1;
    localparam logic [1:0]  ST_GAP   = 2'd2;
    localparam logic [1:0]  ST_DONE  = 2'd3;
    localparam logic [15:0] MIN_L    = 16'd60;
    localparam logic [15:0] MAX_L    = 16'(MAX_LEN);

    logic [1:0]        state_q, state_d;
    logic [12:0]       beat_q, beat_d;
    logic [15:0]       len_q, len_d, ifg_q, ifg_d, gap_q, gap_d, typ_q, typ_d;
    logic [47:0]       dst_q, dst_d, src_q, src_d;
    logic [31:0]       count_q, count_d, run_q, run_d, stat_q, stat_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;

    logic              start, load, stop, reached, quiet;
    logic [31:0]       seq_n;
    logic [12:0]       f_beat;
    logic [15:0]       f_len, k, len_clamped;
    logic [143:0]      f_hdr;

    assign len_clamped = (cfg_len < MIN_L) ? MIN_L : ((cfg_len > MAX_L) ? MAX_L : cfg_len);

    always_comb begin
        state_d = state_q;  beat_d  = beat_q;  len_d   = len_q;   ifg_d  = ifg_q;
        gap_d   = gap_q;    typ_d   = typ_q;   dst_d   = dst_q;   src_d  = src_q;
        count_d = count_q;  run_d   = run_q;   stat_d  = stat_q;
        tvalid_d = tvalid_q; tlast_d = tlast_q; tdata_d = tdata_q; tkeep_d = tkeep_q;
        start = 1'b0; load = 1'b0; stop = 1'b0; reached = 1'b0; quiet = 1'b0;
        seq_n = run_q; k = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    run_d = '0;
                    seq_n = '0;
                    start = 1'b1;
                end
            end
            ST_FRAME: begin
                if (tvalid_q && m_axis_tx.tready) begin
                    if (tlast_q) begin
                        run_d   = run_q + 32'd1;
                        stat_d  = stat_q + 32'd1;
                        seq_n   = run_d;
                        reached = (count_q != 32'd0) && (run_d == count_q);
                        if (!enable || reached) begin
                            stop = 1'b1;
                        end else if (ifg_q == 16'd0) begin
                            start = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = ifg_q;
                            quiet   = 1'b1;
                        end
                    end else begin
                        load   = 1'b1;
                        beat_d = beat_q + 13'd1;
                    end
                end
            end
            ST_GAP: begin
                // gap_q holds the remaining idle cycles including the current one
                if (gap_q <= 16'd1) begin
                    reached = (count_q != 32'd0) && (run_q == count_q);
                    if (!enable || reached) stop = 1'b1;
                    else                    start = 1'b1;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: begin
                if (!enable) state_d = ST_IDLE;
            end
        endcase

        if (stop) begin
            state_d = reached ? ST_DONE : ST_IDLE;
            quiet   = 1'b1;
        end

        if (start) begin
            state_d = ST_FRAME;
            dst_d   = cfg_dst_mac;
            src_d   = cfg_src_mac;
            typ_d   = cfg_eth_type;
            len_d   = len_clamped;
            ifg_d   = cfg_ifg;
            count_d = cfg_count;
            beat_d  = '0;
            load    = 1'b1;
        end

        // Beat 0 of a new frame is built from live cfg; later beats from the latched copy.
        f_beat = start ? 13'd0 : beat_q + 13'd1;
        f_len  = start ? len_clamped : len_q;
        f_hdr  = start ? {cfg_dst_mac, cfg_src_mac, cfg_eth_type, seq_n}
                       : {dst_q, src_q, typ_q, run_q};

        if (load) begin
            tvalid_d = 1'b1;
            tlast_d  = ({f_beat, 3'b000} + 16'd8) >= f_len;
            for (int i = 0; i < KEEP_W; i++) begin
                k = {f_beat, i[2:0]};
                tkeep_d[i] = (k < f_len);
                if (k >= f_len)        tdata_d[8*i +: 8] = 8'h00;
                else if (k < 16'd18)   tdata_d[8*i +: 8] = 8'(f_hdr >> {5'd17 - k[4:0], 3'b000});
                else                   tdata_d[8*i +: 8] = k[7:0];
            end
        end else if (quiet) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            len_q    <= '0;
            ifg_q    <= '0;
            gap_q    <= '0;
            typ_q    <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            count_q  <= '0;
            run_q    <= '0;
            stat_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            ifg_q    <= ifg_d;
            gap_q    <= gap_d;
            typ_q    <= typ_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            count_q  <= count_d;
            run_q    <= run_d;
            stat_q   <= stat_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
        end
    end

    assign m_axis_tx.tdata  = tdata_q;
    assign m_axis_tx.tkeep  = tkeep_q;
    assign m_axis_tx.tvalid = tvalid_q;
    assign m_axis_tx.tlast  = tlast_q;
    assign m_axis_tx.tid    = '0;
    assign m_axis_tx.tdest  = '0;
    assign m_axis_tx.tuser  = '0;
    assign busy        = (state_q == ST_FRAME) || (state_q == ST_GAP);
    assign done        = (state_q == ST_DONE);
    assign stat_frames = stat_q;

endmodule

// File: tb/tb_taxi_eth_frame_gen.sv
// tb/tb_taxi_eth_frame_gen.sv - self-checking bench for taxi_eth_frame_gen
module tb_taxi_eth_frame_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [47:0] cfg_dst_mac, cfg_src_mac;
    logic [15:0] cfg_eth_type, cfg_len, cfg_ifg;
    logic [31:0] cfg_count;
    logic        busy, done;
    logic [31:0] stat_frames;

    int   checks = 0;
    int   failures = 0;
    int   run_id = 0;
    int   total_frames = 0;
    bit   rand_ready = 1'b0;
    logic tready_fix = 1'b1;

    logic [31:0] m_seq;
    int          m_beat, run_beats, run_frames, low_cnt;
    bit          in_gap, prev_stall;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;
    logic [63:0] cap_data [0:1199];
    logic [7:0]  cap_keep [0:1199];

    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(64), .KEEP_W(8), .USER_W(1)) axis ();

    taxi_eth_frame_gen #(.DATA_W(64), .KEEP_W(8), .MAX_LEN(9600)) dut (
        .clk(clk), .rst_n(rst_n), .m_axis_tx(axis), .enable(enable),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac), .cfg_eth_type(cfg_eth_type),
        .cfg_len(cfg_len), .cfg_ifg(cfg_ifg), .cfg_count(cfg_count),
        .busy(busy), .done(done), .stat_frames(stat_frames)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        if (len < 60)   return 60;
        if (len > 9600) return 9600;
        return len;
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input int L, input logic [31:0] seq);
        if (k >= L) return 8'h00;
        if (k < 6)  return 8'(cfg_dst_mac >> (8*(5-k)));
        if (k < 12) return 8'(cfg_src_mac >> (8*(11-k)));
        if (k < 14) return 8'(cfg_eth_type >> (8*(13-k)));
        if (k < 18) return 8'(seq >> (8*(17-k)));
        return 8'(k);
    endfunction

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1 axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : tready_fix;
        end
    endtask

    task automatic monitor();
        int seen = 0;
        int L, nb, k;
        logic [63:0] ed;
        logic [7:0]  ek;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_beat = 0; in_gap = 0; prev_stall = 0;
                continue;
            end
            if (run_id != seen) begin
                seen = run_id; m_seq = '0; m_beat = 0; run_beats = 0; run_frames = 0; in_gap = 0;
            end
            if (prev_stall) begin
                chk("stall_tvalid", 64'(axis.tvalid), 64'd1);
                chk("stall_tdata", axis.tdata, prev_data);
                chk("stall_tkeep", 64'(axis.tkeep), 64'(prev_keep));
                chk("stall_tlast", 64'(axis.tlast), 64'(prev_last));
            end
            if (axis.tvalid) begin
                if (in_gap) begin
                    chk("ifg_cycles", 64'(low_cnt), 64'(cfg_ifg));
                    in_gap = 0;
                end
                if (axis.tready) begin
                    L  = clamp_len(int'(cfg_len));
                    nb = (L + 7) / 8;
                    for (int lane = 0; lane < 8; lane++) begin
                        k = m_beat*8 + lane;
                        ed[8*lane +: 8] = exp_byte(k, L, m_seq);
                        ek[lane] = (k < L);
                    end
                    chk("beat_tdata", axis.tdata, ed);
                    chk("beat_tkeep", 64'(axis.tkeep), 64'(ek));
                    chk("beat_tlast", 64'(axis.tlast), 64'(m_beat == nb - 1));
                    cap_data[m_beat] = axis.tdata;
                    cap_keep[m_beat] = axis.tkeep;
                    run_beats++;
                    if (m_beat == nb - 1) begin
                        m_beat = 0; m_seq = m_seq + 32'd1; run_frames++;
                        in_gap = 1; low_cnt = 0;
                    end else begin
                        m_beat++;
                    end
                end
            end else if (in_gap) begin
                low_cnt++;
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_keep  = axis.tkeep;
            prev_last  = axis.tlast;
        end
    endtask

    task automatic run_counted(input int len, input int cnt, input int ifg, input bit rnd, input int budget);
        int c = 0;
        cfg_len = 16'(len); cfg_count = 32'(cnt); cfg_ifg = 16'(ifg); rand_ready = rnd;
        run_id++;
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        chk("pre_start_tvalid", 64'(axis.tvalid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("start_latency_tvalid", 64'(axis.tvalid), 64'd1);
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("done_reached", 64'(done), 64'd1);
        total_frames += cnt;
        chk("run_frames", 64'(run_frames), 64'(cnt));
        chk("run_beats", 64'(run_beats), 64'(cnt * ((clamp_len(len) + 7) / 8)));
        chk("stat_frames", 64'(stat_frames), 64'(total_frames));
        chk("tvalid_after_done", 64'(axis.tvalid), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
        rand_ready = 1'b0;
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("done_cleared", 64'(done), 64'd0);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; enable = 1'b0; axis.tready = 1'b1;
        cfg_dst_mac = 48'h02_11_22_33_44_55; cfg_src_mac = 48'h02_AA_BB_CC_DD_EE;
        cfg_eth_type = 16'h88B5; cfg_len = 16'd60; cfg_ifg = 16'd0; cfg_count = 32'd1;
        fork
            ready_drv();
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tlast", 64'(axis.tlast), 64'd0);
        chk("rst_tdata", axis.tdata, 64'd0);
        chk("rst_tkeep", 64'(axis.tkeep), 64'd0);
        chk("rst_tuser", 64'(axis.tuser), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stat", 64'(stat_frames), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_counted(60, 1, 0, 1'b0, 100);
        chk("t1_beat0", cap_data[0], 64'hAA02_5544_3322_1102);
        chk("t1_beat1", cap_data[1], 64'h0000_B588_EEDD_CCBB);
        chk("t1_beat2", cap_data[2], 64'h1716_1514_1312_0000);
        chk("t1_beat7", cap_data[7], 64'h0000_0000_3B3A_3938);
        chk("t1_keep7", 64'(cap_keep[7]), 64'h0F);

        run_counted(64, 3, 0, 1'b0, 100);
        chk("t2_seq2_beat2", cap_data[2], 64'h1716_1514_1312_0200);
        chk("t2_keep7", 64'(cap_keep[7]), 64'hFF);

        cfg_dst_mac = 48'(64'($urandom) << 16) ^ 48'($urandom);
        cfg_src_mac = 48'(64'($urandom) << 16) ^ 48'($urandom);
        cfg_eth_type = 16'($urandom);
        run_counted(1000, 3, 5, 1'b1, 4000);
        chk("t3_keep124", 64'(cap_keep[124]), 64'hFF);

        run_counted(10, 1, 0, 1'b0, 100);
        chk("t4_min_keep7", 64'(cap_keep[7]), 64'h0F);
        run_counted(20000, 1, 0, 1'b0, 2000);
        chk("t4_max_last", cap_data[1199], 64'h7F7E_7D7C_7B7A_7978);

        cfg_len = 16'd100; cfg_count = 32'd0; cfg_ifg = 16'd2;
        run_id++;
        @(posedge clk);
        #1 enable = 1'b1;
        c = 0;
        while (run_beats < 3 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("t5_reached_beat3", 64'(run_beats >= 3), 64'd1);
        @(posedge clk);
        #1 enable = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < 200);
        total_frames += 1;
        chk("t5_busy_dropped", 64'(busy), 64'd0);
        chk("t5_frames", 64'(run_frames), 64'd1);
        chk("t5_keep12", 64'(cap_keep[12]), 64'h0F);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_stat", 64'(stat_frames), 64'(total_frames));
        repeat (3) @(negedge clk);
        chk("t5_idle_tvalid", 64'(axis.tvalid), 64'd0);
        chk("t5_idle_busy", 64'(busy), 64'd0);

        cfg_len = 16'd200; tready_fix = 1'b0;
        run_id++;
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_stalled_tvalid", 64'(axis.tvalid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_tvalid", 64'(axis.tvalid), 64'd0);
        chk("t6_async_tdata", axis.tdata, 64'd0);
        chk("t6_async_busy", 64'(busy), 64'd0);
        chk("t6_async_stat", 64'(stat_frames), 64'd0);
        enable = 1'b0; tready_fix = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_post_rst_tvalid", 64'(axis.tvalid), 64'd0);
        end
        total_frames = 0;
        run_counted(60, 1, 0, 1'b0, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/taxi_eth_frame_gen.md
# taxi_eth_frame_gen

Ethernet test-frame generator that sources complete frames into the transmit AXI4-Stream interface of a 10G/25G MAC (64-bit datapath, FCS appended by the MAC). It is the traffic-source end of the MAC TX path, replacing an RX→TX loopback FIFO when the board must originate traffic itself. Frames carry a programmable header, a 32-bit big-endian sequence number and a deterministic byte pattern, so a far-end receiver/checker can detect loss and corruption.

## Interface
- `DATA_W`, 64: tdata width; only 64 is supported (elaboration error otherwise).
- `KEEP_W`, `DATA_W/8`: tkeep width.
- `MAX_LEN`, 9600: upper clamp on frame length in bytes, excluding FCS.

Ports:
- `clk` input 1: sole clock (MAC tx_clk domain).
- `rst_n` input 1: reset, asynchronous assert, active-low. Synchronous deassert is the integrator's responsibility.
- `m_axis_tx` taxi_axis_if source, DATA_W=64/KEEP_W=8/USER_W=1: frame output; tid/tdest/tuser driven 0.
- `enable` input 1: run request, level-sensitive.
- `cfg_dst_mac` input 48: destination MAC; `[47:40]` is wire byte 0.
- `cfg_src_mac` input 48: source MAC; `[47:40]` is wire byte 6.
- `cfg_eth_type` input 16: EtherType, `[15:8]` is byte 12.
- `cfg_len` input 16: frame length in bytes excluding FCS, clamped to [60, MAX_LEN].
- `cfg_ifg` input 16: idle cycles with tvalid low between frames.
- `cfg_count` input 32: frames per run; 0 = continuous.
- `busy` output 1: high in FRAME or GAP.
- `done` output 1: high in DONE.
- `stat_frames` output 32: total frames completed since reset (wraps).

## Operation
- Byte k of a frame sits in lane k mod 8 of beat k/8. Layout:
  - bytes 0-5: dst
  - bytes 6-11: src
  - bytes 12-13: eth_type
  - bytes 14-17: seq[31:24..7:0]
  - byte k ≥ 18: k[7:0]
- seq is the run frame index; the first frame of a run carries 0.
- All cfg_* inputs are latched at frame start (IDLE→FRAME and GAP→FRAME). Changes mid-frame take effect on the next frame.
- Beats per frame: ceil(L/8), where L is the clamped length. The last beat has tlast=1 and tkeep = low (L mod 8) bits set, or 0xFF if L mod 8 = 0. All other beats have tkeep=0xFF. Unused lanes of the last beat carry 0.
- FSM:
  - IDLE: if enable, go to FRAME; clear the run counter.
  - FRAME: advance one beat per handshake. On the last-beat handshake, increment the run counter and stat_frames, then:
    - if enable=0, or cfg_count≠0 and run counter = cfg_count: go to DONE if the count was reached, else IDLE;
    - else if cfg_ifg=0: go to FRAME (next frame);
    - else: go to GAP.
  - GAP: load cfg_ifg into a down-counter and hold tvalid low. When the count expires, re-evaluate the FRAME exit conditions (enable / count) and go to FRAME, IDLE or DONE.
  - DONE: hold until enable=0, then go to IDLE. A new run requires an enable low→high cycle.
- Deasserting enable never truncates a frame; the current frame completes.
- AXI rules: once tvalid is asserted, tvalid/tdata/tkeep/tlast stay stable until tready. tready low stalls with no other effect, including on the last beat.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, tkeep=0, busy=0, done=0, stat_frames=0, FSM=IDLE. While rst_n is low, all outputs are forced to these values asynchronously. A reset mid-frame abandons the frame; the MAC sees tvalid drop without tlast.
- enable sampled high at edge N in IDLE → beat 0 valid from the cycle following edge N (one-cycle latency).
- Sustained throughput is one beat per cycle while tready=1; registered outputs, no bubbles inside a frame.
- cfg_ifg=0 → beat 0 of the next frame is valid in the cycle after the last-beat handshake, with zero idle cycles.
- cfg_ifg=G>0 → exactly G cycles of tvalid=0 between the last-beat handshake and the next beat 0.
- busy/done/stat_frames update in the cycle after the qualifying handshake.
- stat_frames wraps 0xFFFFFFFF→0. The run counter is 32-bit; with cfg_count=0 it wraps silently and seq wraps with it.

## Test plan
- Reset, then enable=1, cfg_len=60, cfg_count=1, tready=1 → 8 beats; beat 7 has tkeep=0x0F and tlast=1; bytes 14-17 = 00 00 00 00; byte 18 = 0x12; done=1; stat_frames=1.
- cfg_len=64, cfg_count=3, cfg_ifg=0, tready=1 → 24 consecutive valid beats; last beats have tkeep=0xFF; seq values 0,1,2; done=1; tvalid=0 afterwards.
- cfg_len=1000, cfg_ifg=5, random tready backpressure (50%) → data stable while stalled; exactly 5 tvalid-low cycles between frames; 125 beats/frame; last tkeep=0xFF.
- cfg_len=10 and cfg_len=20000 → frames of 60 and 9600 bytes respectively (clamped).
- Continuous mode: drop enable in the middle of beat 3 → frame completes with tlast; FSM returns to IDLE; done stays 0.
- Assert rst_n=0 mid-frame with tready=0 → tvalid=0 immediately (same cycle); after release, tvalid stays 0 until enable is sampled high.
